// File: rtl/inst_fetch_buf.sv
// Prefetch buffer between PC generation and IF/ID.
// Issues in-order ROM reads and queues {pc, inst} pairs for decode.
module inst_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic [5:0]    stall_i,
  input  logic          flush_i,
  output logic          rom_req_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic          rom_gnt_i,
  input  logic          rom_rvalid_i,
  input  logic [DW-1:0] rom_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          stallreq_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] tw_q, tw_d;
  logic [PW-1:0] tr_q, tr_d;

  logic [AW-1:0] tag_q [DEPTH];
  logic [AW-1:0] pc_q  [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          drop;
  logic [CW:0]   used;
  logic          unused_stall;

  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  // Slots are reserved at issue time, so a full FIFO can never overflow.
  assign used       = {1'b0, occ_q} + {1'b0, outst_q};
  assign rom_req_o  = ce_i & ~flush_i & (used < (CW+1)'(DEPTH));
  assign rom_addr_o = pc_i;
  assign accept     = rom_req_o & rom_gnt_i;
  assign stallreq_o = ce_i & ~flush_i & ~accept;

  assign inst_valid_o = (occ_q != '0);
  assign inst_o       = inst_valid_o ? dat_q[rd_q] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_q[rd_q] : '0;

  assign pop  = inst_valid_o & ~stall_i[1];
  assign drop = flush_i | (disc_q != '0);
  assign push = rom_rvalid_i & ~drop;

  always_comb begin
    outst_d = outst_q + CW'(accept) - CW'(rom_rvalid_i);
    tw_d    = tw_q + PW'(accept);
    tr_d    = tr_q + PW'(rom_rvalid_i);
    occ_d   = '0;
    wr_d    = '0;
    rd_d    = '0;
    disc_d  = outst_d;
    if (!flush_i) begin
      occ_d  = occ_q + CW'(push) - CW'(pop);
      wr_d   = wr_q + PW'(push);
      rd_d   = rd_q + PW'(pop);
      disc_d = disc_q - CW'(rom_rvalid_i & (disc_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      tw_q    <= '0;
      tr_q    <= '0;
    end else begin
      occ_q   <= occ_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tw_q    <= tw_d;
      tr_q    <= tr_d;
    end
  end

  // Tag FIFO tracks every in-flight read, including discarded ones.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[tw_q] <= pc_i;
    end
    if (push) begin
      pc_q[wr_q]  <= tag_q[tr_q];
      dat_q[wr_q] <= rom_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Randomized scoreboard bench for inst_fetch_buf.
// A memory model and an in-order expectation queue drive the checks.
module tb_inst_fetch_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        stallreq_o;

  inst_fetch_buf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_gnt_i(rom_gnt_i), .rom_rvalid_i(rom_rvalid_i),
    .rom_rdata_i(rom_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } rd_t;

  rd_t         pend[$];
  logic [63:0] exp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          jit = 0;
  int          first_acc = -1;
  int          first_val = -1;
  int          n_acc = 0;
  logic [31:0] pc_m = 32'h0;
  bit          prev_fl = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1234};
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic step(input bit ce, input bit st, input bit fl,
                      input bit gnt, input bit r = 1'b0);
    int  slots;
    bit  acc;
    @(negedge clk);
    cyc++;
    slots = exp_q.size();
    foreach (pend[i]) if (pend[i].stale) slots++;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rom_rvalid_i = 1'b1;
      rom_rdata_i  = memf(pend[0].addr);
      void'(pend.pop_front());
    end
    rst       = r;
    ce_i      = ce;
    pc_i      = pc_m;
    stall_i   = 6'($urandom) & 6'b111101;
    stall_i[1] = st;
    flush_i   = fl;
    rom_gnt_i = gnt;
    #1;
    if (r) begin
      exp_q.delete();
      pend.delete();
    end else begin
      chk("req", 64'(rom_req_o), 64'(ce & ~fl & (slots < DEPTH)));
      if (rom_req_o) chk("addr", 64'(rom_addr_o), 64'(pc_m));
      acc = rom_req_o & gnt;
      if (acc) begin
        exp_q.push_back({pc_m, memf(pc_m)});
        pend.push_back('{pc_m, cyc + lat + int'($urandom_range(0, jit)), 1'b0});
        if (first_acc < 0) first_acc = cyc;
        n_acc++;
        pc_m += 32'd4;
      end
      if (fl) begin
        exp_q.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        pc_m = $urandom & 32'hfffc;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0 && pend.size() == 0) break;
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("drain", 64'(exp_q.size() + pend.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands an entry to IF/ID.
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (rst !== 1'b1) begin
      if (!inst_valid_o) chk("zero_when_invalid", {inst_pc_o, inst_o}, 64'd0);
      chk("stallreq", 64'(stallreq_o),
          64'(ce_i & ~flush_i & ~(rom_req_o & rom_gnt_i)));
      if (prev_fl) chk("valid_after_flush", 64'(inst_valid_o), 64'd0);
      if (flush_i) chk("flush_no_req", 64'(rom_req_o), 64'd0);
      if (inst_valid_o && first_val < 0) first_val = cyc;
      if (inst_valid_o && !stall_i[1] && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", {inst_pc_o, inst_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("entry", {inst_pc_o, inst_o}, e);
        end
      end
      prev_fl = flush_i;
    end else begin
      prev_fl = 1'b0;
    end
  end

  initial begin
    int a0;
    rst = 1'b1; ce_i = 1'b0; pc_i = '0; stall_i = '0; flush_i = 1'b0;
    rom_gnt_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = '0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_outs", {31'd0, rom_req_o, inst_valid_o, stallreq_o,
        inst_o}, 64'd0);
    chk("reset_pc", 64'(inst_pc_o), 64'd0);

    // Zero-wait memory, streaming
    lat = 1; jit = 0; pc_m = 32'h0;
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("first_latency", 64'(first_val - first_acc), 64'd2);

    // Long stall fills the FIFO
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("full_req", 64'(rom_req_o), 64'd0);
    chk("full_stallreq", 64'(stallreq_o), 64'd1);
    // Full FIFO with simultaneous push and pop, pointers wrap
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Flush with two late reads outstanding
    lat = 3;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("two_outstanding", 64'(pend.size()), 64'd2);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Grant withheld for three cycles
    lat = 1; pc_m = 32'h100; a0 = n_acc;
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("gnt_low_stall", 64'(stallreq_o), 64'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("issued_once", 64'(n_acc - a0), 64'd1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      lat = int'($urandom_range(1, 3));
      jit = int'($urandom_range(0, 2));
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-operation
    lat = 2; jit = 0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_outs", {31'd0, rom_req_o, inst_valid_o, stallreq_o,
        inst_o}, 64'd0);
    chk("rst_mid_pc", 64'(inst_pc_o), 64'd0);
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
